// File: rtl/matmul_seq.sv
// Sequencer that hands one matrix job at a time to an external multiplier and holds its result.
// Optional watchdog on the WAIT state is compiled in with `define MATMUL_SEQ_TIMEOUT_EN.
module matmul_seq #(
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned MAX_DIM       = BUS_WIDTH / DATA_WIDTH,
    localparam int unsigned OP_W          = MAX_DIM * BUS_WIDTH,
    localparam int unsigned RES_W         = MAX_DIM * MAX_DIM * BUS_WIDTH,
    localparam int unsigned OF_W          = MAX_DIM * MAX_DIM
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [OP_W-1:0]  a_row_i,
    input  logic [OP_W-1:0]  b_col_i,

    output logic [OP_W-1:0]  mul_a_row_o,
    output logic [OP_W-1:0]  mul_b_col_o,
    output logic             mul_start_o,
    input  logic             mul_busy_i,
    input  logic             mul_done_i,
    input  logic [OF_W-1:0]  mul_ouflow_i,
    input  logic [RES_W-1:0] mul_res_i,

    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [RES_W-1:0] res_data_o,
    output logic [OF_W-1:0]  res_ouflow_o,

    output logic             busy_o,
    output logic             err_timeout_o,
    input  logic             err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    logic [OP_W-1:0]    r_a_row;
    logic [OP_W-1:0]    r_b_col;
    logic [RES_W-1:0]   r_res;
    logic [OF_W-1:0]    r_ouflow;
    logic               r_start;
    logic               r_valid;
    logic               r_busy;
    logic               r_job_ready;
    logic               r_armed;

    logic               w_seen;
    logic               w_accept;

    // A done only counts once the multiplier has been seen busy for this job.
    assign w_seen   = r_armed | mul_busy_i;
    assign w_accept = mul_done_i & w_seen;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               w_expire;
    logic               w_timeout_set;

    assign w_expire      = (r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
    assign w_timeout_set = (r_state == S_WAIT) && w_expire && !w_accept;

    // Sticky error; a new timeout outranks a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_timeout_set) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign err_timeout_o = r_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr_i;
    assign err_timeout_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_a_row     <= '0;
            r_b_col     <= '0;
            r_res       <= '0;
            r_ouflow    <= '0;
            r_start     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_job_ready <= 1'b1;
            r_armed     <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (job_valid_i && r_job_ready) begin
                        r_a_row     <= a_row_i;
                        r_b_col     <= b_col_i;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_job_ready <= 1'b0;
                        r_state     <= S_START;
                    end
                end

                S_START: begin
                    r_start <= 1'b0;
                    r_armed <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_accept) begin
                        r_res    <= mul_res_i;
                        r_ouflow <= mul_ouflow_i;
                        r_valid  <= 1'b1;
                        r_state  <= S_OUT;
                    end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                    else if (w_expire) begin
                        r_busy      <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
`endif
                    else begin
                        if (mul_busy_i) begin
                            r_armed <= 1'b1;
                        end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end

                S_OUT: begin
                    if (res_ready_i) begin
                        r_valid     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready_o  = r_job_ready;
    assign mul_a_row_o  = r_a_row;
    assign mul_b_col_o  = r_b_col;
    assign mul_start_o  = r_start;
    assign res_valid_o  = r_valid;
    assign res_data_o   = r_res;
    assign res_ouflow_o = r_ouflow;
    assign busy_o       = r_busy;

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameters: BUS_WIDTH, default 32, result/operand-word width; DATA_WIDTH, default 8, element width; TIMEOUT_CYCLES, default 64, watchdog limit; MAX_DIM is local, equal to BUS_WIDTH/DATA_WIDTH.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 job_valid_i  in  1  job offered; job_ready_o  out  1  controller can accept a job.
REQ-005 a_row_i, b_col_i  in  MAX_DIM*BUS_WIDTH each  job operands, sampled on job accept.
REQ-006 mul_a_row_o, mul_b_col_o  out  MAX_DIM*BUS_WIDTH each  operands to the multiplier.
REQ-007 mul_start_o  out  1  start pulse to the multiplier; mul_busy_i  in  1  multiplier busy; mul_done_i  in  1  multiplier done.
REQ-008 mul_ouflow_i  in  MAX_DIM*MAX_DIM; mul_res_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  multiplier result.
REQ-009 res_valid_o  out  1; res_ready_i  in  1  result handshake.
REQ-010 res_data_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH; res_ouflow_o  out  MAX_DIM*MAX_DIM  captured result and overflow flags.
REQ-011 busy_o  out  1  high in any state other than IDLE.
REQ-012 err_timeout_o  out  1  sticky watchdog error; err_clr_i  in  1  clears it.

Function
REQ-013 FSM states: IDLE, START, WAIT, OUT; job_ready_o is high only in IDLE.
REQ-014 IDLE: when job_valid_i and job_ready_o are both high, register a_row_i/b_col_i into the operand registers and go to START the next cycle.
REQ-015 START: assert mul_start_o for exactly one cycle, clear the armed flag and watchdog counter, then go to WAIT.
REQ-016 mul_a_row_o/mul_b_col_o come from the operand registers and stay stable from START until the FSM returns to IDLE.
REQ-017 WAIT: set the armed flag on the first cycle mul_busy_i is high; accept mul_done_i only while armed, or in the same cycle busy is first seen.
REQ-018 WAIT on accepted done: capture mul_res_i into res_data_o and mul_ouflow_i into res_ouflow_o, then go to OUT; the first captured data is visible in the OUT cycle.
REQ-019 OUT: hold res_valid_o high with res_data_o/res_ouflow_o stable until res_ready_i is high; return to IDLE the cycle after that handshake.
REQ-020 mul_done_i and mul_busy_i are ignored in IDLE, START and OUT.
REQ-021 Latency: job accept to mul_start_o is 1 cycle; accepted done to res_valid_o is 1 cycle.
REQ-022 res_ready_i while res_valid_o is low has no effect; job_valid_i outside IDLE is not accepted and is not queued.
REQ-023 err_timeout_o: err_clr_i clears it; a timeout set in the same cycle as err_clr_i wins.

Reset
REQ-024 While rst_i is high: FSM in IDLE; operand, result and overflow registers all zero; mul_start_o, res_valid_o, err_timeout_o and busy_o low; job_ready_o high after release.
REQ-025 Reset asserted mid-job discards the job; no start pulse and no result are produced for it.

Configuration
REQ-026 Macro MATMUL_SEQ_TIMEOUT_EN, when defined, compiles in the watchdog.
- The counter increments each WAIT cycle.
- When it reaches TIMEOUT_CYCLES without an accepted done: set err_timeout_o and return to IDLE with no result.
- An accepted done in the same cycle as expiry wins (normal capture, no error).
REQ-027 Without MATMUL_SEQ_TIMEOUT_EN: no counter; WAIT waits indefinitely; err_timeout_o is tied low and err_clr_i is ignored.

Verification
REQ-028 Basic job, A=identity, B=all elements 2:
- Accept job; mul_start_o pulses once.
- busy high 3 cycles, then done -> res_valid_o high, res_data_o matches mul_res_i, res_ouflow_o=0.
REQ-029 Backpressure: hold res_ready_i low 10 cycles in OUT -> res_valid_o and res_data_o stable all 10 cycles; IDLE one cycle after ready.
REQ-030 Stale done:
- mul_done_i already high at start and busy not yet seen -> no capture.
- Capture occurs only after busy is seen, then done.
REQ-031 Reset mid-WAIT: assert rst_i 1 cycle -> all outputs return to reset values; no res_valid_o for the aborted job; a new job is accepted normally.
REQ-032 With MATMUL_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no done:
- err_timeout_o set on the 8th WAIT cycle, FSM returns to IDLE.
- err_clr_i clears it.
- Done on the expiry cycle -> result captured, no error.
REQ-033 Back-to-back jobs with job_valid_i held high:
- The second job is accepted only after the first result handshake.
- Operands stay stable across the first job.
